mod_seq: RTL

MOD_SEQ -- requirements
Module: mod_seq

---
 rtl/mod_seq.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mod_seq.sv
// mod_seq: sequential unsigned divider using repeated subtraction.
//
// A request is accepted on a rising edge where Start=1 and the FSM is in
// IDLE. The operands are latched on that edge, then the remainder register
// is reduced by the divisor once per clock until it drops below the divisor.
// Quotient counts the subtractions. A zero divisor is flagged on DivZero and
// leaves Remainder=A and Quotient=0.
//
// Ports
//   clk        rising-edge clock for all state
//   reset      synchronous, active-high reset
//   Start      request pulse, honoured only in IDLE
//   A, B       32-bit unsigned dividend / divisor, sampled on acceptance
//   Busy       high while an operation is in flight (CALC or DONE)
//   Done       one-cycle completion pulse (DONE state)
//   DivZero    latched divisor was zero; held until the next acceptance
//   Remainder  A mod B; held until the next acceptance
//   Quotient   floor(A/B); held until the next acceptance
//
// state | meaning
// ------+--------------------------------------------------------
// IDLE  | waiting for Start; results of the last operation held
// CALC  | one subtraction per clock while R >= Bq
// DONE  | result valid, Done pulse, returns to IDLE next edge

module mod_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic        Done,
  output logic        DivZero,
  output logic [31:0] Remainder,
  output logic [31:0] Quotient
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] r_q;
  logic [31:0] q_q;
  logic [31:0] bq_q;
  logic        dz_q;
  logic        bq_zero;
  logic        r_ge_b;

  assign bq_zero = (bq_q == 32'd0);
  assign r_ge_b  = (r_q >= bq_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = IDLE;
    Busy      = 1'b0;
    Done      = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = Start ? CALC : IDLE;
      end
      CALC: begin
        Busy = 1'b1;
        // A zero divisor must finish immediately: R >= 0 always holds,
        // so the subtract loop would otherwise never terminate.
        if (bq_zero || !r_ge_b) begin
          state_nxt = DONE;
        end else begin
          state_nxt = CALC;
        end
      end
      DONE: begin
        Busy      = 1'b1;
        Done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q  <= 32'd0;
      q_q  <= 32'd0;
      bq_q <= 32'd0;
      dz_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            r_q  <= A;
            q_q  <= 32'd0;
            bq_q <= B;
            dz_q <= 1'b0;
          end
        end
        CALC: begin
          if (bq_zero) begin
            dz_q <= 1'b1;
          end else if (r_ge_b) begin
            r_q <= r_q - bq_q;
            q_q <= q_q + 32'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign DivZero   = dz_q;
  assign Remainder = r_q;
  assign Quotient  = q_q;

endmodule
